hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 112 +++++++++++
 tb/tb_hazard_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: operand forwarding selects, data/MDU stall and the
// mult/div busy countdown.
module hazard_ctrl #(
    parameter int unsigned MULT_CYC = 5,
    parameter int unsigned DIV_CYC  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] RS_D,
    input  logic [4:0] RT_D,
    input  logic [1:0] TUSE_RS_D,
    input  logic [1:0] TUSE_RT_D,
    input  logic [4:0] RS_E,
    input  logic [4:0] RT_E,
    input  logic [4:0] RT_M,
    input  logic [4:0] A3_E,
    input  logic [4:0] A3_M,
    input  logic [4:0] A3_W,
    input  logic [1:0] TNEW_E,
    input  logic [1:0] TNEW_M,
    input  logic       MD_START_E,
    input  logic       MD_DIV_E,
    input  logic       MD_USE_D,
    output logic [1:0] FWD_RS_D,
    output logic [1:0] FWD_RT_D,
    output logic [1:0] FWD_RS_E,
    output logic [1:0] FWD_RT_E,
    output logic       FWD_RT_M,
    output logic       STALL,
    output logic       MD_BUSY,
    output logic [3:0] MD_CNT
);

    localparam int unsigned CNT_W = 4;

    localparam logic [1:0] SEL_NONE = 2'd0;
    localparam logic [1:0] SEL_E    = 2'd1;
    localparam logic [1:0] SEL_M    = 2'd2;
    localparam logic [1:0] SEL_W    = 2'd3;

    logic match_e_rs, match_m_rs, match_w_rs;
    logic match_e_rt, match_m_rt, match_w_rt;
    logic stall_e_rs, stall_m_rs, stall_e_rt, stall_m_rt;
    logic data_stall, md_stall;
    logic [CNT_W-1:0] md_load;

    // A stage matches a source only when it writes a real register.
    always_comb begin
        match_e_rs = (A3_E != 5'd0) && (A3_E == RS_D);
        match_m_rs = (A3_M != 5'd0) && (A3_M == RS_D);
        match_w_rs = (A3_W != 5'd0) && (A3_W == RS_D);
        match_e_rt = (A3_E != 5'd0) && (A3_E == RT_D);
        match_m_rt = (A3_M != 5'd0) && (A3_M == RT_D);
        match_w_rt = (A3_W != 5'd0) && (A3_W == RT_D);
    end

    // Stall when the consumer needs the value before its producer has it.
    always_comb begin
        stall_e_rs = match_e_rs && (TUSE_RS_D < TNEW_E);
        stall_m_rs = match_m_rs && (TUSE_RS_D < TNEW_M);
        stall_e_rt = match_e_rt && (TUSE_RT_D < TNEW_E);
        stall_m_rt = match_m_rt && (TUSE_RT_D < TNEW_M);
        data_stall = stall_e_rs || stall_m_rs || stall_e_rt || stall_m_rt;
        md_stall   = MD_USE_D && (MD_BUSY || MD_START_E);
        STALL      = data_stall || md_stall;
    end

    // D-stage forwarding; a stalled E match hides older M/W copies.
    always_comb begin
        FWD_RS_D = SEL_NONE;
        if (match_e_rs && (TNEW_E == 2'd0))      FWD_RS_D = SEL_E;
        else if (stall_e_rs)                     FWD_RS_D = SEL_NONE;
        else if (match_m_rs && (TNEW_M == 2'd0)) FWD_RS_D = SEL_M;
        else if (match_w_rs)                     FWD_RS_D = SEL_W;

        FWD_RT_D = SEL_NONE;
        if (match_e_rt && (TNEW_E == 2'd0))      FWD_RT_D = SEL_E;
        else if (stall_e_rt)                     FWD_RT_D = SEL_NONE;
        else if (match_m_rt && (TNEW_M == 2'd0)) FWD_RT_D = SEL_M;
        else if (match_w_rt)                     FWD_RT_D = SEL_W;
    end

    // E-stage and M-stage forwarding.
    always_comb begin
        FWD_RS_E = SEL_NONE;
        if ((A3_M != 5'd0) && (A3_M == RS_E) && (TNEW_M == 2'd0)) FWD_RS_E = SEL_M;
        else if ((A3_W != 5'd0) && (A3_W == RS_E))               FWD_RS_E = SEL_W;

        FWD_RT_E = SEL_NONE;
        if ((A3_M != 5'd0) && (A3_M == RT_E) && (TNEW_M == 2'd0)) FWD_RT_E = SEL_M;
        else if ((A3_W != 5'd0) && (A3_W == RT_E))               FWD_RT_E = SEL_W;

        FWD_RT_M = (A3_W != 5'd0) && (A3_W == RT_M);
    end

    assign md_load = MD_DIV_E ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);

    // Busy countdown; a new start is ignored while the unit is busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            MD_CNT  <= '0;
            MD_BUSY <= 1'b0;
        end else if (MD_START_E && !MD_BUSY) begin
            MD_CNT  <= md_load;
            MD_BUSY <= (md_load != '0);
        end else if (MD_CNT != '0) begin
            MD_CNT  <= MD_CNT - CNT_W'(1);
            MD_BUSY <= (MD_CNT != CNT_W'(1));
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding, data stall, MDU countdown and reset.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] RS_D, RT_D, RS_E, RT_E, RT_M, A3_E, A3_M, A3_W;
    logic [1:0] TUSE_RS_D, TUSE_RT_D, TNEW_E, TNEW_M;
    logic       MD_START_E, MD_DIV_E, MD_USE_D;
    logic [1:0] FWD_RS_D, FWD_RT_D, FWD_RS_E, FWD_RT_E;
    logic       FWD_RT_M, STALL, MD_BUSY;
    logic [3:0] MD_CNT;

    int errors = 0;
    int checks = 0;
    int stall_cycles;

    hazard_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
        .clk(clk), .reset(reset),
        .RS_D(RS_D), .RT_D(RT_D), .TUSE_RS_D(TUSE_RS_D), .TUSE_RT_D(TUSE_RT_D),
        .RS_E(RS_E), .RT_E(RT_E), .RT_M(RT_M),
        .A3_E(A3_E), .A3_M(A3_M), .A3_W(A3_W),
        .TNEW_E(TNEW_E), .TNEW_M(TNEW_M),
        .MD_START_E(MD_START_E), .MD_DIV_E(MD_DIV_E), .MD_USE_D(MD_USE_D),
        .FWD_RS_D(FWD_RS_D), .FWD_RT_D(FWD_RT_D),
        .FWD_RS_E(FWD_RS_E), .FWD_RT_E(FWD_RT_E), .FWD_RT_M(FWD_RT_M),
        .STALL(STALL), .MD_BUSY(MD_BUSY), .MD_CNT(MD_CNT)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_pipe();
        RS_D = 0; RT_D = 0; RS_E = 0; RT_E = 0; RT_M = 0;
        A3_E = 0; A3_M = 0; A3_W = 0;
        TUSE_RS_D = 2'd3; TUSE_RT_D = 2'd3; TNEW_E = 0; TNEW_M = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_pipe();
        MD_START_E = 0; MD_DIV_E = 0; MD_USE_D = 0;
        reset = 1'b1;
        #1;
        check("rst_cnt", MD_CNT, 0);
        check("rst_busy", MD_BUSY, 0);
        check("rst_stall", STALL, 0);
        @(negedge clk);
        reset = 1'b0;

        // E producer not ready vs. ready
        RS_D = 5; TUSE_RS_D = 0; A3_E = 5; TNEW_E = 1; #1;
        check("e_stall", STALL, 1);
        TNEW_E = 0; #1;
        check("e_ready_stall", STALL, 0);
        check("e_ready_fwd", FWD_RS_D, 1);

        // Priority E > M > W
        clear_pipe();
        RS_D = 8; TUSE_RS_D = 0; A3_E = 8; A3_M = 8; A3_W = 8; #1;
        check("prio_e", FWD_RS_D, 1);
        A3_E = 0; #1;
        check("prio_m", FWD_RS_D, 2);
        A3_M = 0; #1;
        check("prio_w", FWD_RS_D, 3);

        // Register 0 never matches
        clear_pipe();
        RT_D = 0; A3_E = 0; TNEW_E = 2; TUSE_RT_D = 0; #1;
        check("r0_stall", STALL, 0);
        check("r0_fwd", FWD_RT_D, 0);

        // M-stage stall and its boundary
        clear_pipe();
        RT_D = 7; TUSE_RT_D = 1; A3_M = 7; TNEW_M = 2; #1;
        check("m_stall", STALL, 1);
        TNEW_M = 1; #1;
        check("m_nostall", STALL, 0);
        check("m_notready_fwd", FWD_RT_D, 0);

        // Stalled E match blocks M forward; unused source never stalls
        clear_pipe();
        RS_D = 6; TUSE_RS_D = 0; A3_E = 6; TNEW_E = 2; A3_M = 6; #1;
        check("block_stall", STALL, 1);
        TUSE_RS_D = 3; A3_M = 0; #1;
        check("unused_src", STALL, 0);

        // E/M stage forwarding
        clear_pipe();
        RS_E = 4; A3_M = 4; A3_W = 4; #1;
        check("fwd_rs_e_m", FWD_RS_E, 2);
        TNEW_M = 1; #1;
        check("fwd_rs_e_w", FWD_RS_E, 3);
        check("fwd_rt_e_none", FWD_RT_E, 0);
        RT_E = 4; TNEW_M = 0; #1;
        check("fwd_rt_e_m", FWD_RT_E, 2);
        RT_M = 9; A3_W = 9; #1;
        check("fwd_rt_m_hit", FWD_RT_M, 1);
        A3_W = 0; #1;
        check("fwd_rt_m_miss", FWD_RT_M, 0);
        clear_pipe();

        // Divide: 10 busy cycles, 11 stall cycles with the start cycle
        @(negedge clk);
        MD_START_E = 1; MD_DIV_E = 1; MD_USE_D = 1; #1;
        stall_cycles = int'(STALL);
        check("div_start_stall", STALL, 1);
        @(negedge clk);
        MD_START_E = 0;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("div_cnt%0d", i), MD_CNT, 10 - i);
            check($sformatf("div_busy%0d", i), MD_BUSY, 1);
            stall_cycles += int'(STALL);
            @(negedge clk);
        end
        check("div_done_cnt", MD_CNT, 0);
        check("div_done_busy", MD_BUSY, 0);
        stall_cycles += int'(STALL);
        check("div_stall_cycles", stall_cycles, 11);

        // Multiply with a second start while busy is ignored
        MD_USE_D = 0; MD_START_E = 1; MD_DIV_E = 0;
        @(negedge clk);
        MD_START_E = 0;
        check("mul_load", MD_CNT, 5);
        @(negedge clk);
        check("mul_4", MD_CNT, 4);
        @(negedge clk);
        check("mul_3", MD_CNT, 3);
        MD_START_E = 1; MD_DIV_E = 1;
        @(negedge clk);
        check("mul_2", MD_CNT, 2);
        @(negedge clk);
        check("mul_1", MD_CNT, 1);
        MD_START_E = 0;
        @(negedge clk);
        check("mul_0", MD_CNT, 0);
        check("mul_idle", MD_BUSY, 0);
        @(negedge clk);
        check("mul_hold0", MD_CNT, 0);

        // Async reset mid-countdown
        MD_START_E = 1; MD_DIV_E = 1;
        @(negedge clk);
        MD_START_E = 0;
        repeat (4) @(negedge clk);
        check("pre_rst_cnt", MD_CNT, 6);
        #2 reset = 1'b1;
        #1;
        check("async_rst_cnt", MD_CNT, 0);
        check("async_rst_busy", MD_BUSY, 0);
        MD_USE_D = 1; RS_D = 3; A3_W = 3; #1;
        check("rst_md_stall", STALL, 0);
        check("rst_fwd", FWD_RS_D, 3);
        @(negedge clk);
        MD_USE_D = 0; clear_pipe();
        reset = 1'b0;
        MD_START_E = 1; MD_DIV_E = 0;
        @(negedge clk);
        MD_START_E = 0;
        check("post_rst_load", MD_CNT, 5);
        check("post_rst_busy", MD_BUSY, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
